data_memory_ctrl: RTL and testbench
===================================

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and a reset that is asynchronous and active-low.
REQ-002 Parameter BANKS, default 2, meaning number of 16K x 32 SPRAM banks stacked in depth (legal 1..2).
REQ-003 Parameter SIGNED_LOADS, default 1, meaning LB/LH sign-extend (0 forces zero-extend for all loads).
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_funct3  input  3  RV32 size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  response for the request accepted the previous cycle.
REQ-013 rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned, out of range or had illegal funct3.
REQ-015 busy  output  1  clear sequence in progress.

Function
REQ-016 A request SHALL be accepted on any rising edge where req_valid and req_ready are both 1; req_ready SHALL be 1 in every IDLE cycle, giving one request per cycle throughput.
REQ-017 Every accepted request SHALL produce exactly one rsp_valid pulse exactly one cycle later; rsp_valid SHALL be 0 otherwise.
REQ-018 Word index = req_addr[31:2]; bank = index[14], row = index[13:0]; index >= 16384*BANKS SHALL set rsp_err and suppress the access.
REQ-019 Misalignment (halfword with addr[0]=1, word with addr[1:0]!=0) or funct3 outside the seven legal codes SHALL set rsp_err, suppress the access, and return rsp_rdata=0.
REQ-020 Stores SHALL replicate req_wdata into the addressed lanes and drive the nibble write mask: SB lane k -> nibbles 2k,2k+1; SH -> low or high four nibbles by addr[1]; SW -> all eight.
REQ-021 Loads SHALL select the byte/halfword by registered addr[1:0], then sign- or zero-extend per funct3 and SIGNED_LOADS.
REQ-022 Only the selected bank SHALL see chip-select; unselected banks SHALL be idle.
REQ-023 A load issued the cycle after a store to the same word SHALL return the newly stored data.
REQ-024 FSM states: CLEAR (zero-fill), IDLE; CLEAR -> IDLE when the row counter wraps from 16383 to 0; IDLE has no exit except reset.
REQ-025 In CLEAR, every bank SHALL be written with 0 at row counter value each cycle, req_ready=0, busy=1; clear takes exactly 16384 cycles.

Reset
REQ-026 While rst_n=0: rsp_valid=0, rsp_rdata=0, rsp_err=0, row counter=0, req_ready=0.
REQ-027 busy SHALL reset to 1 when the clear feature is compiled in, otherwise to 0, with FSM in IDLE.
REQ-028 Reset asserted mid-clear or mid-request SHALL abort; the response of the in-flight request SHALL be dropped and the clear SHALL restart from row 0.

Configuration
REQ-029 Macro DMEM_CLEAR_EN defined: reset enters CLEAR and memory reads 0 after busy falls.
REQ-030 Macro DMEM_CLEAR_EN undefined: no CLEAR state, no row counter; IDLE and req_ready=1 on first cycle after reset release; contents undefined.

Structure
REQ-031 Package dmem_pkg SHALL hold the funct3 constants, the FSM state enum, SPRAM_ROWS=16384 and the nibble-mask width 8.
REQ-032 Sub-module dmem_bank SHALL wrap two SB_SPRAM256KA primitives (MSW/LSW) into one 16K x 32 bank with 8-bit nibble mask, chip-select and write-enable; BANKS instances are generated.

Verification
REQ-033 DMEM_CLEAR_EN, release reset -> busy=1 for 16384 cycles, then LW 0x0000_FFFC returns 0x0000_0000.
REQ-034 SW 0x1122_3344 @0x100, SB 0xAA @0x101, LW @0x100 back-to-back -> 0x1122_AA44 on the cycle after the LW.
REQ-035 SH 0x8001 @0x202, LH @0x202 -> 0xFFFF_8001; LHU @0x202 -> 0x0000_8001; SIGNED_LOADS=0 LH -> 0x0000_8001.
REQ-036 LW @0x103, LH @0x001, funct3=011, LW @0x0001_0000 with BANKS=1 -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-037 BANKS=2: SW 0xDEAD_BEEF @0x0000_0010 and SW 0x0BAD_F00D @0x0001_0010 -> each reads back its own value.
REQ-038 Assert rst_n=0 at clear row 5000 -> responses and ready stay 0; after release, clear runs a full 16384 cycles again.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data memory controller: RV32 funct3 codes,
// controller state encoding and SPRAM geometry.
package dmem_pkg;

  localparam int SPRAM_ROWS = 16384;
  localparam int NIB_W      = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_bank.sv
// One 16K x 32 data bank built from two SPRAM cells (MSW holds bits 31:16,
// LSW holds bits 15:0), with an 8-bit nibble write mask.
module dmem_bank
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             cs_i,
  input  logic             we_i,
  input  logic [13:0]      row_i,
  input  logic [31:0]      wdata_i,
  input  logic [NIB_W-1:0] mask_i,
  output logic [31:0]      rdata_o
);

  SB_SPRAM256KA u_msw (
    .ADDRESS    (row_i),
    .DATAIN     (wdata_i[31:16]),
    .MASKWREN   (mask_i[7:4]),
    .WREN       (we_i),
    .CHIPSELECT (cs_i),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (rdata_o[31:16])
  );

  SB_SPRAM256KA u_lsw (
    .ADDRESS    (row_i),
    .DATAIN     (wdata_i[15:0]),
    .MASKWREN   (mask_i[3:0]),
    .WREN       (we_i),
    .CHIPSELECT (cs_i),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (rdata_o[15:0])
  );

endmodule

// File: rtl/dmem_spram_sim.sv
// Behavioural stand-in for the iCE40UP SB_SPRAM256KA (16K x 16, nibble write mask,
// registered read port). Leave this file out when the vendor cell library supplies the cell.
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem [0:16383];
  logic [15:0] dout_q;
  logic        active;

  // POWEROFF is active-low on the real cell
  assign active = CHIPSELECT && !STANDBY && !SLEEP && POWEROFF;

  always_ff @(posedge CLOCK) begin
    if (active && WREN) begin
      for (int n = 0; n < 4; n++) begin
        if (MASKWREN[n]) mem[ADDRESS][4*n +: 4] <= DATAIN[4*n +: 4];
      end
    end else if (active) begin
      dout_q <= mem[ADDRESS];
    end
  end

  assign DATAOUT = dout_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// RV32 load/store port onto BANKS x (16K x 32) SPRAM banks, one request per cycle,
// response one cycle later. Define DMEM_CLEAR_EN to zero-fill memory after reset.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int BANKS        = 2,
  parameter int SIGNED_LOADS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  function automatic logic [NIB_W-1:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_mask = 8'b0000_0011 << {off, 1'b0};
      2'b01:   store_mask = off[1] ? 8'hF0 : 8'h0F;
      default: store_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h  = off[1] ? w[31:16] : w[15:0];
    sx = (SIGNED_LOADS != 0) && !f3[2];
    case (f3[1:0])
      2'b00:   load_ext = {{24{sx & b[7]}}, b};
      2'b01:   load_ext = {{16{sx & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  logic [29:0]      idx;
  logic             f3_ok;
  logic             misalign;
  logic             range_err;
  logic             req_bad;
  logic             fire;
  logic             acc;
  logic             clearing;
  logic [13:0]      clr_row;
  logic [13:0]      mem_row;
  logic [31:0]      mem_wdata;
  logic [NIB_W-1:0] mem_mask;
  logic             mem_we;
  logic [31:0]      bank_rdata [2];

  assign idx      = req_addr[31:2];
  assign f3_ok    = req_we ? (req_funct3 == F3_SB || req_funct3 == F3_SH || req_funct3 == F3_SW)
                           : (req_funct3 == F3_LB || req_funct3 == F3_LH || req_funct3 == F3_LW ||
                              req_funct3 == F3_LBU || req_funct3 == F3_LHU);
  assign misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign range_err = idx >= 30'(SPRAM_ROWS * BANKS);
  assign req_bad   = !f3_ok || misalign || range_err;
  assign fire      = req_valid && req_ready;
  assign acc       = fire && !req_bad;

`ifdef DMEM_CLEAR_EN
  dmem_state_e state_q, state_d;
  logic [13:0] row_q, row_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    if (state_q == ST_CLEAR) begin
      row_d = row_q + 14'd1;
      if (row_q == 14'(SPRAM_ROWS - 1)) state_d = ST_IDLE;
    end
  end

  // Reset always restarts the zero-fill from row 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  assign clearing  = (state_q == ST_CLEAR);
  assign clr_row   = row_q;
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = clearing;
`else
  logic ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign clearing  = 1'b0;
  assign clr_row   = '0;
  assign req_ready = ready_q;
  assign busy      = 1'b0;
`endif

  assign mem_row   = clearing ? clr_row : idx[13:0];
  assign mem_wdata = clearing ? '0 : store_data(req_funct3, req_wdata);
  assign mem_mask  = clearing ? '1 : store_mask(req_funct3, req_addr[1:0]);
  assign mem_we    = clearing || req_we;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic cs_b;
    assign cs_b = clearing || (acc && (idx[14] == 1'(b)));

    dmem_bank u_bank (
      .clk     (clk),
      .cs_i    (cs_b),
      .we_i    (mem_we),
      .row_i   (mem_row),
      .wdata_i (mem_wdata),
      .mask_i  (mem_mask),
      .rdata_o (bank_rdata[b])
    );
  end

  if (BANKS < 2) begin : g_no_bank1
    assign bank_rdata[1] = '0;
  end

  // Response stage: control flags reset, lane/format selectors only follow accepted requests
  logic       rsp_valid_q;
  logic       rsp_err_q;
  logic       ld_q;
  logic [1:0] off_q;
  logic [2:0] f3_q;
  logic       bank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ld_q        <= 1'b0;
    end else begin
      rsp_valid_q <= fire;
      rsp_err_q   <= fire && req_bad;
      ld_q        <= acc && !req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      off_q  <= req_addr[1:0];
      f3_q   <= req_funct3;
      bank_q <= idx[14];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = ld_q ? load_ext(bank_rdata[bank_q], off_q, f3_q) : '0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomised bench for data_memory_ctrl against a byte-level reference model, with
// literal checks; dut0 = BANKS 2 / signed loads, dut1 = BANKS 1 / zero-extended loads.
`timescale 1ns/1ps
module tb_data_memory_ctrl;

`ifdef DMEM_CLEAR_EN
  localparam logic [3:0] CLR_KNOWN = 4'hF;
  localparam logic       RST_BUSY  = 1'b1;
`else
  localparam logic [3:0] CLR_KNOWN = 4'h0;
  localparam logic       RST_BUSY  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld [2];
  logic        we  [2];
  logic        rdy [2];
  logic        rv  [2];
  logic        re  [2];
  logic        bsy [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] rd   [2];
  logic [2:0]  f3   [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rd;
    logic        kn;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] mw[int];
  logic [3:0]  mk[int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_ctrl #(.BANKS(2), .SIGNED_LOADS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_addr(addr[0]), .req_funct3(f3[0]), .req_wdata(wd[0]), .rsp_valid(rv[0]),
    .rsp_rdata(rd[0]), .rsp_err(re[0]), .busy(bsy[0])
  );

  data_memory_ctrl #(.BANKS(1), .SIGNED_LOADS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_addr(addr[1]), .req_funct3(f3[1]), .req_wdata(wd[1]), .rsp_valid(rv[1]),
    .rsp_rdata(rd[1]), .rsp_err(re[1]), .busy(bsy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: memory as bytes per word, with a per-byte "known" mask
  function automatic void model(input int d, input logic w, input logic [31:0] a,
                                input logic [2:0] f, input logic [31:0] wdat,
                                output logic e, output logic [31:0] r, output logic kn);
    int banks, nb, off, idx, key;
    bit legal, sgn;
    logic [31:0] word, msk;
    logic [3:0]  km;
    banks = (d == 0) ? 2 : 1;
    sgn   = (d == 0);
    idx   = int'(a >> 2);
    off   = int'(a[1:0]);
    nb    = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    e     = !legal || (off % nb != 0) || (idx >= 16384 * banks);
    r     = '0;
    kn    = 1'b1;
    if (e) return;
    key = d * 32768 + idx;
    if (mw.exists(key)) begin
      word = mw[key];
      km   = mk[key];
    end else begin
      word = '0;
      km   = CLR_KNOWN;
    end
    if (w) begin
      for (int i = 0; i < nb; i++) begin
        word[8*(off+i) +: 8] = wdat[8*i +: 8];
        km[off+i] = 1'b1;
      end
      mw[key] = word;
      mk[key] = km;
    end else begin
      msk = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      r   = (word >> (8 * off)) & msk;
      if (sgn && !f[2] && nb < 4 && r[8*nb-1]) r = r | ~msk;
      for (int i = 0; i < nb; i++) if (!km[off+i]) kn = 1'b0;
    end
  endfunction

  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [2:0] f,
                       input logic [31:0] wdat);
    exp_t x;
    @(negedge clk);
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    vld[d] = 1'b1; we[d] = w; addr[d] = a; f3[d] = f; wd[d] = wdat;
    #1;
    chk("issue_ready", 32'(rdy[d]), 32'd1);
    if (!rdy[d]) begin
      vld[d] = 1'b0;
      return;
    end
    model(d, w, a, f, wdat, x.err, x.rd, x.kn);
    x.due = cyc + 1;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    vld[0] = 1'b0;
    vld[1] = 1'b0;
  endtask

  task automatic check_lit(input int d, input string nm, input logic [31:0] exp_rd,
                           input logic exp_err);
    @(negedge clk);
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    #1;
    chk({nm, "_valid"}, 32'(rv[d]), 32'd1);
    chk({nm, "_rdata"}, rd[d], exp_rd);
    chk({nm, "_err"}, 32'(re[d]), 32'(exp_err));
  endtask

  task automatic reset_checks(input string nm, input logic exp_busy);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_rsp_valid"}, 32'(rv[d]), 32'd0);
      chk({nm, "_rsp_rdata"}, rd[d], 32'd0);
      chk({nm, "_rsp_err"}, 32'(re[d]), 32'd0);
      chk({nm, "_req_ready"}, 32'(rdy[d]), 32'd0);
      chk({nm, "_busy"}, 32'(bsy[d]), 32'(exp_busy));
    end
  endtask

  task automatic cmp(input int d);
    exp_t x;
    bit   have;
    have = 1'b0;
    if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin x = q0.pop_front(); have = 1'b1; end
    if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin x = q1.pop_front(); have = 1'b1; end
    chk(d == 0 ? "rsp_valid0" : "rsp_valid1", 32'(rv[d]), 32'(have));
    if (have) begin
      chk(d == 0 ? "rsp_err0" : "rsp_err1", 32'(re[d]), 32'(x.err));
      if (x.kn) chk(d == 0 ? "rsp_rdata0" : "rsp_rdata1", rd[d], x.rd);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0);
      cmp(1);
    end
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; f3[d] = '0; wd[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset_checks("reset", RST_BUSY);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
    repeat (5000) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    reset_checks("abort_clear", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rv[0] || rdy[0]) break;
    end while (bsy[0] && n < 20000);
    chk("clear_cycles", 32'(n), 32'd16384);
    chk("clear_ready0", 32'(rdy[0]), 32'd1);
    chk("clear_busy1", 32'(bsy[1]), 32'd0);
    chk_en = 1'b1;
    issue(0, 1'b0, 32'h0000_FFFC, 3'b010, '0);
    check_lit(0, "zero_after_clear", 32'h0000_0000, 1'b0);
`else
    @(negedge clk);
    #1;
    chk("ready_after_release0", 32'(rdy[0]), 32'd1);
    chk("ready_after_release1", 32'(rdy[1]), 32'd1);
    chk("busy_idle0", 32'(bsy[0]), 32'd0);
    chk_en = 1'b1;
`endif

    for (int r = 0; r < 32; r++) begin
      issue(0, 1'b1, 32'(r * 4), 3'b010, '0);
      issue(0, 1'b1, 32'((16384 + r) * 4), 3'b010, '0);
      issue(1, 1'b1, 32'(r * 4), 3'b010, '0);
    end

    issue(0, 1'b1, 32'h0000_0100, 3'b010, 32'h1122_3344);
    issue(0, 1'b1, 32'h0000_0101, 3'b000, 32'h0000_00AA);
    issue(0, 1'b0, 32'h0000_0100, 3'b010, '0);
    check_lit(0, "sw_sb_lw", 32'h1122_AA44, 1'b0);

    issue(0, 1'b1, 32'h0000_0202, 3'b001, 32'h0000_8001);
    issue(0, 1'b0, 32'h0000_0202, 3'b001, '0);
    check_lit(0, "lh_signed", 32'hFFFF_8001, 1'b0);
    issue(0, 1'b0, 32'h0000_0202, 3'b101, '0);
    check_lit(0, "lhu", 32'h0000_8001, 1'b0);
    issue(1, 1'b1, 32'h0000_0202, 3'b001, 32'h0000_8001);
    issue(1, 1'b0, 32'h0000_0202, 3'b001, '0);
    check_lit(1, "lh_unsigned_cfg", 32'h0000_8001, 1'b0);

    issue(0, 1'b0, 32'h0000_0103, 3'b010, '0);
    check_lit(0, "lw_misaligned", 32'h0, 1'b1);
    issue(0, 1'b0, 32'h0000_0001, 3'b001, '0);
    check_lit(0, "lh_misaligned", 32'h0, 1'b1);
    issue(0, 1'b0, 32'h0000_0000, 3'b011, '0);
    check_lit(0, "bad_funct3", 32'h0, 1'b1);
    issue(1, 1'b0, 32'h0001_0000, 3'b010, '0);
    check_lit(1, "out_of_range", 32'h0, 1'b1);
    issue(0, 1'b1, 32'h0000_0103, 3'b010, 32'hFFFF_FFFF);
    issue(0, 1'b1, 32'h0000_0100, 3'b011, 32'hFFFF_FFFF);
    issue(0, 1'b0, 32'h0000_0100, 3'b010, '0);
    check_lit(0, "unchanged_after_err", 32'h1122_AA44, 1'b0);

    issue(0, 1'b1, 32'h0000_0010, 3'b010, 32'hDEAD_BEEF);
    issue(0, 1'b1, 32'h0001_0010, 3'b010, 32'h0BAD_F00D);
    issue(0, 1'b0, 32'h0000_0010, 3'b010, '0);
    check_lit(0, "bank0_word", 32'hDEAD_BEEF, 1'b0);
    issue(0, 1'b0, 32'h0001_0010, 3'b010, '0);
    check_lit(0, "bank1_word", 32'h0BAD_F00D, 1'b0);

    for (int i = 0; i < 800; i++) begin
      int          d, off, nb;
      logic        w;
      logic [2:0]  f;
      logic [31:0] a;
      d = ($urandom_range(0, 3) == 0) ? 1 : 0;
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
      else if (w) f = 3'($urandom_range(0, 2));
      else case ($urandom_range(0, 4))
        0: f = 3'b000;
        1: f = 3'b001;
        2: f = 3'b010;
        3: f = 3'b100;
        default: f = 3'b101;
      endcase
      nb  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 4) != 0) off = off - (off % nb);
      a = 32'(($urandom_range(0, 31) + ((d == 0) ? 16384 * $urandom_range(0, 1) : 0)) * 4 + off);
      if ($urandom_range(0, 19) == 0) a = a + ((d == 0) ? 32'h0002_0000 : 32'h0001_0000);
      if ($urandom_range(0, 49) == 0) a = a | 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) idle();
      else issue(d, w, a, f, $urandom);
    end
    idle();
    idle();

    chk_en = 1'b0;
    issue(0, 1'b0, 32'h0000_0100, 3'b010, '0);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    vld[0] = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    #1;
    reset_checks("abort_request", RST_BUSY);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
